pc_fetch_ctrl: RTL and testbench

- Sequences the program counter register and instruction-memory fetch for the RV32 core.
- Owns the PC, issues one fetch at a time to instruction memory over a req/gnt + rvalid handshake, and presents fetched instructions downstream with valid/ready.
- Redirects (branch/jump) from execute replace the PC and discard any in-flight or held wrong-path instruction.

---
 rtl/pc_fetch_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Program counter owner and instruction fetch sequencer for the RV32 core.
// Issues one fetch at a time to instruction memory (req/gnt, then rvalid),
// holds the returned instruction and hands it downstream with valid/ready.
// A redirect from execute replaces the PC and discards any in-flight or
// held wrong-path instruction.
//
// Parameters:
//   WIDTH     PC / address width in bits
//   RESET_PC  PC loaded on reset (4-byte aligned)
//
// Ports:
//   clk_i             system clock, rising edge
//   rst_ni            asynchronous active-low reset
//   redirect_valid_i  load redirect_pc_i as next fetch PC, flush fetch path
//   redirect_pc_i     redirect target, bits [1:0] forced to zero
//   imem_req_o        fetch request to instruction memory
//   imem_addr_o       fetch address (always equals pc_o)
//   imem_gnt_i        request accepted this cycle
//   imem_rvalid_i     response data valid
//   imem_rdata_i      instruction word from memory
//   inst_valid_o      held instruction is valid
//   inst_o            held instruction
//   inst_pc_o         PC of the held instruction
//   inst_ready_i      downstream accepts the held instruction
//   pc_o              current fetch PC
//
// Optional feature (macro PC_FETCH_PERF_EN):
//   fetch_cnt_o       saturating count of instruction transfers
//   stall_cnt_o       saturating count of REQ-without-gnt and WAIT cycles
// ---------------------------------------------------------------------------
module pc_fetch_ctrl #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             redirect_valid_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic             imem_gnt_i,
    input  logic             imem_rvalid_i,
    input  logic [31:0]      imem_rdata_i,
    output logic             inst_valid_o,
    output logic [31:0]      inst_o,
    output logic [WIDTH-1:0] inst_pc_o,
    input  logic             inst_ready_i,
`ifdef PC_FETCH_PERF_EN
    output logic [31:0]      fetch_cnt_o,
    output logic [31:0]      stall_cnt_o,
`endif
    output logic [WIDTH-1:0] pc_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_e;

    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(3));
    localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);
    localparam logic [WIDTH-1:0] RESET_PC_A = RESET_PC & ALIGN_MASK;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             kill_q, kill_d;
    logic [31:0]      inst_q, inst_d;
    logic [WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic [WIDTH-1:0] redirect_target;

    // Masking the whole vector keeps pc[1:0] at zero for every redirect.
    assign redirect_target = redirect_pc_i & ALIGN_MASK;

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC_A;
            kill_q    <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            kill_q    <= kill_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    // Next-state logic. A redirect always wins: it rewrites the PC in every
    // state, and a fetch already granted is marked killed so its response is
    // dropped rather than captured. rvalid is only looked at in WAIT, so a
    // stale response arriving after reset is ignored.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        kill_d    = kill_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;

        case (state_q)
            IDLE: begin
                if (redirect_valid_i) pc_d = redirect_target;
                state_d = REQ;
            end
            REQ: begin
                if (redirect_valid_i) pc_d = redirect_target;
                if (imem_gnt_i) begin
                    state_d = WAIT;
                    kill_d  = redirect_valid_i;
                end
            end
            WAIT: begin
                if (redirect_valid_i) pc_d = redirect_target;
                if (imem_rvalid_i) begin
                    if (kill_q || redirect_valid_i) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        inst_d    = imem_rdata_i;
                        inst_pc_d = pc_q;
                        pc_d      = pc_q + PC_STEP;
                        state_d   = HOLD;
                    end
                end else if (redirect_valid_i) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid_i) begin
                    pc_d    = redirect_target;
                    state_d = REQ;
                end else if (inst_ready_i) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs come only from registers or the state decode.
    assign imem_req_o   = (state_q == REQ);
    assign imem_addr_o  = pc_q;
    assign pc_o         = pc_q;
    assign inst_valid_o = (state_q == HOLD);
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;

`ifdef PC_FETCH_PERF_EN
    logic        transfer;
    logic        stall;
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    assign transfer = (state_q == HOLD) && inst_ready_i && !redirect_valid_i;
    assign stall    = ((state_q == REQ) && !imem_gnt_i) || (state_q == WAIT);

    // Saturating performance counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (transfer && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//
// Cycle-stepped bench for pc_fetch_ctrl. A small instruction memory model
// grants on request and answers in the second WAIT cycle; surviving fetches
// are pushed onto a scoreboard and popped when the DUT hands them off.
// Per-cycle expectations for req/addr/valid/inst_pc come from a vector table,
// followed by hand-written reset and IDLE-redirect sequences.
// ---------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        gnt;
        logic        ready;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expInstPc;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        redirectValid = 1'b0;
    logic [31:0] redirectPc = '0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt = 1'b0;
    logic        imemRvalid = 1'b0;
    logic [31:0] imemRdata = '0;
    logic        instValid;
    logic [31:0] inst;
    logic [31:0] instPc;
    logic        instReady = 1'b0;
    logic [31:0] pc;

    int checks = 0;
    int failures = 0;

    exp_t expQ[$];

    // Memory model state.
    logic        memPending = 1'b0;
    logic        memKilled = 1'b0;
    logic [31:0] memAddr = '0;
    logic [31:0] memExpAddr = '0;
    int          memCount = 0;
    int          memWait = 1;
    logic [31:0] expAddrPrev = '0;

    pc_fetch_ctrl dut (
        .clk_i           (clk),
        .rst_ni          (rstN),
        .redirect_valid_i(redirectValid),
        .redirect_pc_i   (redirectPc),
        .imem_req_o      (imemReq),
        .imem_addr_o     (imemAddr),
        .imem_gnt_i      (imemGnt),
        .imem_rvalid_i   (imemRvalid),
        .imem_rdata_i    (imemRdata),
        .inst_valid_o    (instValid),
        .inst_o          (inst),
        .inst_pc_o       (instPc),
        .inst_ready_i    (instReady),
        .pc_o            (pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return {a[24:0], 7'h13};
    endfunction

    function automatic vec_t mk(input logic r, input logic [31:0] rp, input logic g,
                                input logic rd, input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ei);
        vec_t v;
        v.redir = r; v.rpc = rp; v.gnt = g; v.ready = rd;
        v.expReq = er; v.expAddr = ea; v.expValid = ev; v.expInstPc = ei;
        return v;
    endfunction

    task automatic checkEq(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Called just after a rising edge: drives one cycle of inputs at the
    // falling edge, runs the scoreboard and memory model, then advances.
    task automatic applyStimulus(input logic redir, input logic [31:0] rpc,
                                 input logic gnt, input logic ready);
        exp_t e;
        @(negedge clk);
        redirectValid = redir;
        redirectPc    = rpc;
        imemGnt       = gnt;
        instReady     = ready;
        imemRvalid    = memPending && (memCount == 0);
        imemRdata     = imemRvalid ? memData(memAddr) : 32'hDEAD_BEEF;
        #1;
        if (instValid && ready && !redir) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL xfer: got transfer of inst_pc 0x%08h expected none", instPc);
            end else begin
                e = expQ.pop_front();
                checkEq("xfer.inst_pc", instPc, e.pc);
                checkEq("xfer.inst", inst, e.data);
            end
        end else if (instValid && redir) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL drop: got held inst_pc 0x%08h expected none held", instPc);
            end else begin
                e = expQ.pop_front();
                checkEq("drop.inst_pc", instPc, e.pc);
            end
        end
        if (imemRvalid) begin
            if (!memKilled && !redir) expQ.push_back({memExpAddr, memData(memExpAddr)});
            memPending = 1'b0;
        end else if (memPending) begin
            if (redir) memKilled = 1'b1;
            memCount--;
        end
        if (imemReq && gnt) begin
            memPending = 1'b1;
            memAddr    = imemAddr;
            memExpAddr = expAddrPrev;
            memKilled  = redir;
            memCount   = memWait;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic expReq, input logic [31:0] expAddr,
                               input logic expValid, input logic [31:0] expInstPc);
        checkEq({tag, ".imem_req"}, {31'b0, imemReq}, {31'b0, expReq});
        checkEq({tag, ".imem_addr"}, imemAddr, expAddr);
        checkEq({tag, ".pc"}, pc, expAddr);
        checkEq({tag, ".inst_valid"}, {31'b0, instValid}, {31'b0, expValid});
        if (expValid) begin
            checkEq({tag, ".inst_pc"}, instPc, expInstPc);
            checkEq({tag, ".inst"}, inst, memData(expInstPc));
        end
        expAddrPrev = expAddr;
    endtask

    task automatic checkReset(input string tag);
        checkEq({tag, ".imem_req"}, {31'b0, imemReq}, 32'h0);
        checkEq({tag, ".inst_valid"}, {31'b0, instValid}, 32'h0);
        checkEq({tag, ".inst"}, inst, 32'h0);
        checkEq({tag, ".inst_pc"}, instPc, 32'h0);
        checkEq({tag, ".pc"}, pc, 32'h0);
        expAddrPrev = 32'h0;
    endtask

    initial begin
        vec_t vecs[$];

        // Basic stream: 4-cycle cadence, inst_pc 0 then 4.
        vecs.push_back(mk(0, 0, 1, 1, 1, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'h4, 1, 32'h0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 32'h4, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'h4, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'h4, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'h8, 1, 32'h4));
        vecs.push_back(mk(0, 0, 1, 1, 1, 32'h8, 0, 0));
        // gnt withheld three cycles at pc 8.
        repeat (3) vecs.push_back(mk(0, 0, 0, 1, 1, 32'h8, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'h8, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'h8, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'hC, 1, 32'h8));
        // HOLD with ready low, then redirect to 0x203 with ready high.
        repeat (5) vecs.push_back(mk(0, 0, 1, 0, 0, 32'hC, 1, 32'h8));
        vecs.push_back(mk(1, 32'h203, 1, 1, 1, 32'h200, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'h200, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'h200, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'h204, 1, 32'h200));
        vecs.push_back(mk(0, 0, 1, 1, 1, 32'h204, 0, 0));
        // Redirect in REQ without gnt, then redirect while in WAIT for 4.
        vecs.push_back(mk(1, 32'h4, 0, 1, 1, 32'h4, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'h4, 0, 0));
        vecs.push_back(mk(1, 32'h100, 1, 1, 0, 32'h100, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 32'h100, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'h100, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'h100, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'h104, 1, 32'h100));
        vecs.push_back(mk(0, 0, 1, 1, 1, 32'h104, 0, 0));
        // gnt and redirect together, then fetch at the top of memory and wrap.
        vecs.push_back(mk(1, 32'hFFFF_FFFC, 1, 1, 0, 32'hFFFF_FFFC, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'hFFFF_FFFC, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 32'hFFFF_FFFC, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'hFFFF_FFFC, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'hFFFF_FFFC, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'h0, 1, 32'hFFFF_FFFC));
        vecs.push_back(mk(0, 0, 1, 1, 1, 32'h0, 0, 0));
        // Redirect in the same cycle as rvalid.
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'h0, 0, 0));
        vecs.push_back(mk(1, 32'h40, 1, 1, 1, 32'h40, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'h40, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'h40, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'h44, 1, 32'h40));
        vecs.push_back(mk(0, 0, 1, 1, 1, 32'h44, 0, 0));

        // Power-on reset.
        repeat (2) @(posedge clk);
        #1;
        checkReset("reset.hold");
        @(posedge clk);
        #1;
        rstN = 1'b1;
        checkReset("reset.release");

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].redir, vecs[i].rpc, vecs[i].gnt, vecs[i].ready);
            checkOutput($sformatf("vec%0d", i), vecs[i].expReq, vecs[i].expAddr,
                        vecs[i].expValid, vecs[i].expInstPc);
        end

        // Reset asserted while waiting on a fetch; the stale response comes
        // back after release and must be ignored.
        applyStimulus(0, 0, 1, 1);
        checkOutput("rst.wait", 0, 32'h44, 0, 0);
        #2;
        rstN          = 1'b0;
        redirectValid = 1'b0;
        imemGnt       = 1'b0;
        imemRvalid    = 1'b0;
        instReady     = 1'b0;
        #1;
        checkReset("rst.async");
        memKilled = 1'b1;
        memCount  = 1;
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        checkReset("rst.after");
        applyStimulus(0, 0, 1, 1);
        checkOutput("rst.c0", 1, 32'h0, 0, 0);
        applyStimulus(0, 0, 1, 1);
        checkOutput("rst.c1", 0, 32'h0, 0, 0);
        applyStimulus(0, 0, 1, 1);
        checkOutput("rst.c2", 0, 32'h0, 0, 0);
        applyStimulus(0, 0, 1, 1);
        checkOutput("rst.c3", 0, 32'h4, 1, 32'h0);
        applyStimulus(0, 0, 1, 1);
        checkOutput("rst.c4", 1, 32'h4, 0, 0);

        // Redirect during the IDLE cycle, with a misaligned target.
        checkEq("sb.drained", expQ.size(), 0);
        #2;
        rstN = 1'b0;
        memPending = 1'b0;
        @(posedge clk);
        #1;
        rstN = 1'b1;
        checkReset("idle.reset");
        applyStimulus(1, 32'h57, 0, 1);
        checkOutput("idle.redir", 1, 32'h54, 0, 0);
        applyStimulus(0, 0, 1, 1);
        checkOutput("idle.gnt", 0, 32'h54, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
